bx_sequencer: RTL and testbench
===============================

# bx_sequencer

- Parametrised successor to the fixed 3-bit BX / start-marker enable logic in the processing top level.
- Watches NCHAN input data channels for a start marker and raises `en_proc`.
- Generates the bunch-crossing counter `BX`, with a programmable number of processing clocks per BX.
- Produces `first_clk` / `not_first_clk` framing strobes for the processing chain, detects markers that arrive out of phase, and supports a synchronous stop.

## Interface
- `NCHAN`, default 3: number of input channels watched for the start marker.
- `DATA_WIDTH`, default 36: width of each channel word.
- `BX_WIDTH`, default 3: BX counter width; BX wraps modulo 2^BX_WIDTH.
- `CLKS_PER_BX`, default 4: processing clocks per BX; legal range 2 to 1024.
- `START_WORD`, default all ones of DATA_WIDTH: marker value.
- `START_MODE`, default "ANY": "ANY" starts on the first channel showing the marker; "ALL" starts once every channel has shown it.
- `clk`  in  1  processing clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  NCHAN*DATA_WIDTH  channel words; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `data_valid`  in  NCHAN  per-channel qualifier; a word is compared only when its valid bit is 1.
- `stop`  in  1  synchronous run stop.
- `en_proc`  out  1  processing enable.
- `BX`  out  BX_WIDTH  current bunch crossing.
- `first_clk`  out  1  high on the first clock of each BX while running.
- `not_first_clk`  out  1  `en_proc & ~first_clk`.
- `clk_cnt`  out  clog2(CLKS_PER_BX)  clock index within the current BX.
- `sync_err`  out  1  one-cycle pulse on an out-of-phase marker.

## Operation
- **Reset values.** All outputs are registered. On reset assertion: `en_proc`=0, `BX`=all ones, `clk_cnt`=0, `first_clk`=0, `not_first_clk`=0, `sync_err`=0, `seen`=0, state=IDLE. Assertion is immediate at any time, including mid-run.
- **Marker hit.** `hit[k]` = `data_valid[k]` & (channel k word == START_WORD).
- **IDLE state:**
  - In "ALL" mode, per-channel sticky flags `seen[k]` are set by `hit[k]`.
  - Start condition, "ANY" mode: |hit.
  - Start condition, "ALL" mode: &(seen | hit). Channels may arrive in different cycles.
  - On start, go to RUN. Next cycle: `en_proc`=1, `BX`=0, `clk_cnt`=0, `first_clk`=1. `seen` is cleared.
  - `stop` in IDLE clears `seen` and is otherwise ignored.
- **RUN state, normal counting:**
  - `clk_cnt` increments each cycle.
  - At `clk_cnt`==CLKS_PER_BX-1 it wraps to 0 and `BX` increments (all-ones wraps to 0).
  - `first_clk`=1 exactly when `clk_cnt`==0.
- **RUN state, markers (checked against the current `clk_cnt`; the start rule is not re-evaluated):**
  - A marker (|hit) at `clk_cnt`==CLKS_PER_BX-1 is aligned: no effect.
  - A marker at any other `clk_cnt` pulses `sync_err` for one cycle.
  - It also realigns the counters: next cycle `clk_cnt`=0, `BX`=BX+1 (mod wrap), `first_clk`=1.
- **Stop:**
  - `stop`=1 in RUN: next cycle state=IDLE, `en_proc`=0, `first_clk`=0, `not_first_clk`=0, `clk_cnt`=0.
  - `BX` holds its last value until the next start, which reloads 0.
- **Simultaneous events:**
  - `stop` and a marker in the same RUN cycle: stop wins and `sync_err` is not raised.
  - `stop` and the start condition in the same IDLE cycle: start wins.

## Timing
- Start latency is 1 clock: condition on edge N gives `en_proc`/`first_clk`/`BX`=0 visible after edge N+1.
- BX period is exactly CLKS_PER_BX clocks absent realignment.
- `first_clk` duty is 1 clock per BX. `not_first_clk` covers the remaining CLKS_PER_BX-1 clocks.
- `sync_err` appears 1 clock after the offending marker, coincident with the realigned `first_clk`.
- Stop latency is 1 clock.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use NCHAN=3, BX_WIDTH=3, CLKS_PER_BX=4 unless noted.
- Reset then idle data, no markers for 20 clocks -> `en_proc`=0, `BX`=7, `first_clk`=0 throughout.
- ANY mode, marker on ch2 at cycle 10 -> cycle 11: `en_proc`=1, `BX`=0, `first_clk`=1. `BX`=1 at cycle 15, 2 at 19. `BX`=7 at cycle 39, 0 at cycle 43.
- ALL mode, markers on ch0 @5, ch2 @7, ch1 @9 -> `en_proc` rises at cycle 10. A repeat ch0 marker at cycle 6 alone does not start.
- Marker at `clk_cnt`=1 during BX=2 -> next cycle `sync_err`=1, `clk_cnt`=0, `BX`=3, `first_clk`=1. A marker at `clk_cnt`=3 gives no `sync_err`.
- `stop` at `BX`=5, `clk_cnt`=2 -> next cycle `en_proc`=0, `BX` holds 5. A later marker restarts with `BX`=0.
- Async reset low mid-run at `BX`=4 -> outputs return to reset values immediately without a clock edge. Release and marker give normal start.

Source files
------------

// File: rtl/bx_sequencer.sv
// BX sequencer: start-marker detection over NCHAN channels, BX / clock-in-BX counting,
// framing strobes, out-of-phase marker realignment and synchronous stop.
module bx_sequencer #(
   parameter int unsigned              NCHAN       = 3,
   parameter int unsigned              DATA_WIDTH  = 36,
   parameter int unsigned              BX_WIDTH    = 3,
   parameter int unsigned              CLKS_PER_BX = 4,
   parameter logic [DATA_WIDTH-1:0]    START_WORD  = '1,
   parameter string                    START_MODE  = "ANY",
   localparam int unsigned             CNT_WIDTH   = $clog2(CLKS_PER_BX)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NCHAN*DATA_WIDTH-1:0]   data_in,
   input  logic [NCHAN-1:0]              data_valid,
   input  logic                          stop,
   output logic                          en_proc,
   output logic [BX_WIDTH-1:0]           BX,
   output logic                          first_clk,
   output logic                          not_first_clk,
   output logic [CNT_WIDTH-1:0]          clk_cnt,
   output logic                          sync_err
);

   localparam bit                   ALL_MODE = (START_MODE == "ALL");
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BX - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t                state_q, state_d;
   logic [NCHAN-1:0]      seen_q, seen_d;
   logic                  en_q, en_d;
   logic [BX_WIDTH-1:0]   bx_q, bx_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  first_q, first_d;
   logic                  nfirst_q, nfirst_d;
   logic                  serr_q, serr_d;

   logic [NCHAN-1:0]      hit;
   logic                  start;

   always_comb begin
      hit = '0;
      for (int unsigned k = 0; k < NCHAN; k++) begin
         hit[k] = data_valid[k] && (data_in[k*DATA_WIDTH +: DATA_WIDTH] == START_WORD);
      end
   end

   // ALL mode accepts markers spread over several cycles via the sticky seen flags
   assign start = ALL_MODE ? &(seen_q | hit) : |hit;

   always_comb begin
      state_d = state_q;
      seen_d  = seen_q;
      en_d    = en_q;
      bx_d    = bx_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      serr_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               seen_d  = '0;
               en_d    = 1'b1;
               bx_d    = '0;
               cnt_d   = '0;
               first_d = 1'b1;
            end else if (stop) begin
               seen_d = '0;
            end else if (ALL_MODE) begin
               seen_d = seen_q | hit;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               en_d    = 1'b0;
               cnt_d   = '0;
               first_d = 1'b0;
            end else if (|hit && (cnt_q != CNT_LAST)) begin
               // out-of-phase marker: flag it and restart the BX on the next clock
               serr_d  = 1'b1;
               cnt_d   = '0;
               bx_d    = bx_q + BX_WIDTH'(1);
               first_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               bx_d    = bx_q + BX_WIDTH'(1);
               first_d = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_WIDTH'(1);
               first_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      nfirst_d = en_d & ~first_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         seen_q   <= '0;
         en_q     <= 1'b0;
         bx_q     <= '1;
         cnt_q    <= '0;
         first_q  <= 1'b0;
         nfirst_q <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         seen_q   <= seen_d;
         en_q     <= en_d;
         bx_q     <= bx_d;
         cnt_q    <= cnt_d;
         first_q  <= first_d;
         nfirst_q <= nfirst_d;
         serr_q   <= serr_d;
      end
   end

   assign en_proc       = en_q;
   assign BX            = bx_q;
   assign first_clk     = first_q;
   assign not_first_clk = nfirst_q;
   assign clk_cnt       = cnt_q;
   assign sync_err      = serr_q;

endmodule

// File: tb/tb_bx_sequencer.sv
// Directed bench for bx_sequencer: one ANY-mode and one ALL-mode instance on shared inputs,
// each held in reset while the other is exercised.
module tb_bx_sequencer;

   localparam int unsigned NCH = 3;
   localparam int unsigned DW  = 36;

   logic               clk = 1'b0;
   logic               rst_any, rst_all;
   logic [NCH*DW-1:0]  data_in;
   logic [NCH-1:0]     data_valid;
   logic               stop;

   logic               a_en, a_f, a_nf, a_se;
   logic [2:0]         a_bx;
   logic [1:0]         a_cnt;
   logic               b_en, b_f, b_nf, b_se;
   logic [2:0]         b_bx;
   logic [1:0]         b_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bx_sequencer #(.NCHAN(NCH), .DATA_WIDTH(DW), .BX_WIDTH(3), .CLKS_PER_BX(4),
                  .START_MODE("ANY")) dut_any (
      .clk(clk), .reset(rst_any), .data_in(data_in), .data_valid(data_valid), .stop(stop),
      .en_proc(a_en), .BX(a_bx), .first_clk(a_f), .not_first_clk(a_nf),
      .clk_cnt(a_cnt), .sync_err(a_se));

   bx_sequencer #(.NCHAN(NCH), .DATA_WIDTH(DW), .BX_WIDTH(3), .CLKS_PER_BX(4),
                  .START_MODE("ALL")) dut_all (
      .clk(clk), .reset(rst_all), .data_in(data_in), .data_valid(data_valid), .stop(stop),
      .en_proc(b_en), .BX(b_bx), .first_clk(b_f), .not_first_clk(b_nf),
      .clk_cnt(b_cnt), .sync_err(b_se));

   typedef struct {
      logic [2:0] mk;
      logic [2:0] vld;
      logic       stp;
      logic       en;
      logic [2:0] bx;
      logic       f;
      logic       nf;
      logic [1:0] cnt;
      logic       se;
   } vec_t;

   vec_t tbl[28];

   function automatic vec_t mkv(input logic [2:0] mk, input logic [2:0] vld, input logic stp,
                                input logic en, input logic [2:0] bx, input logic f,
                                input logic nf, input logic [1:0] cnt, input logic se);
      vec_t v;
      v.mk = mk; v.vld = vld; v.stp = stp; v.en = en; v.bx = bx;
      v.f = f; v.nf = nf; v.cnt = cnt; v.se = se;
      return v;
   endfunction

   task automatic drive(input logic [2:0] mk, input logic [2:0] vld, input logic stp);
      logic [DW-1:0] idle_w;
      for (int k = 0; k < NCH; k++) begin
         idle_w = 36'h0_5A5A_A5A5 ^ DW'(k);
         data_in[k*DW +: DW] = mk[k] ? {DW{1'b1}} : idle_w;
      end
      data_valid = vld;
      stop       = stp;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_out(input bit sel_all, input string nm, input logic en, input logic [2:0] bx,
                          input logic f, input logic nf, input logic [1:0] cnt, input logic se);
      if (!sel_all) begin
         chk({nm, ".en"}, 32'(a_en), 32'(en));
         chk({nm, ".bx"}, 32'(a_bx), 32'(bx));
         chk({nm, ".first"}, 32'(a_f), 32'(f));
         chk({nm, ".nfirst"}, 32'(a_nf), 32'(nf));
         chk({nm, ".cnt"}, 32'(a_cnt), 32'(cnt));
         chk({nm, ".serr"}, 32'(a_se), 32'(se));
      end else begin
         chk({nm, ".en"}, 32'(b_en), 32'(en));
         chk({nm, ".bx"}, 32'(b_bx), 32'(bx));
         chk({nm, ".first"}, 32'(b_f), 32'(f));
         chk({nm, ".nfirst"}, 32'(b_nf), 32'(nf));
         chk({nm, ".cnt"}, 32'(b_cnt), 32'(cnt));
         chk({nm, ".serr"}, 32'(b_se), 32'(se));
      end
   endtask

   initial begin
      // ANY mode: start on ch2, count, misaligned marker at BX2/cnt1, invalid markers,
      // aligned marker, stop at BX5/cnt2, stop+start in IDLE, stop+marker in RUN
      tbl[0]  = mkv(3'b100, 3'b111, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0);
      tbl[1]  = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 2'd1, 1'b0);
      tbl[2]  = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 2'd2, 1'b0);
      tbl[3]  = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 2'd3, 1'b0);
      tbl[4]  = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 2'd0, 1'b0);
      tbl[5]  = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 2'd1, 1'b0);
      tbl[6]  = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 2'd2, 1'b0);
      tbl[7]  = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 2'd3, 1'b0);
      tbl[8]  = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 2'd0, 1'b0);
      tbl[9]  = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 2'd1, 1'b0);
      tbl[10] = mkv(3'b010, 3'b111, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 2'd0, 1'b1);
      tbl[11] = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 2'd1, 1'b0);
      tbl[12] = mkv(3'b111, 3'b000, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 2'd2, 1'b0);
      tbl[13] = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 2'd3, 1'b0);
      tbl[14] = mkv(3'b001, 3'b111, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 2'd0, 1'b0);
      tbl[15] = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 2'd1, 1'b0);
      tbl[16] = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 2'd2, 1'b0);
      tbl[17] = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 2'd3, 1'b0);
      tbl[18] = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 2'd0, 1'b0);
      tbl[19] = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 2'd1, 1'b0);
      tbl[20] = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 2'd2, 1'b0);
      tbl[21] = mkv(3'b000, 3'b111, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 2'd0, 1'b0);
      tbl[22] = mkv(3'b000, 3'b111, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 2'd0, 1'b0);
      tbl[23] = mkv(3'b010, 3'b111, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0);
      tbl[24] = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 2'd1, 1'b0);
      tbl[25] = mkv(3'b000, 3'b111, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 2'd2, 1'b0);
      tbl[26] = mkv(3'b100, 3'b111, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);
      tbl[27] = mkv(3'b000, 3'b111, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);

      rst_any = 1'b0;
      rst_all = 1'b0;
      drive(3'b000, 3'b111, 1'b0);
      repeat (3) tick();
      chk_out(1'b0, "rst_any", 1'b0, 3'd7, 1'b0, 1'b0, 2'd0, 1'b0);
      chk_out(1'b1, "rst_all", 1'b0, 3'd7, 1'b0, 1'b0, 2'd0, 1'b0);
      rst_any = 1'b1;
      rst_all = 1'b1;

      // idle data for 20 clocks; odd cycles carry marker words with valid low
      for (int c = 0; c < 20; c++) begin
         if (c % 2 == 1) drive(3'b111, 3'b000, 1'b0);
         else            drive(3'b000, 3'b111, 1'b0);
         tick();
         chk($sformatf("idle%0d.any.en", c), 32'(a_en), 32'd0);
         chk($sformatf("idle%0d.any.bx", c), 32'(a_bx), 32'd7);
         chk($sformatf("idle%0d.any.first", c), 32'(a_f), 32'd0);
         chk($sformatf("idle%0d.all.en", c), 32'(b_en), 32'd0);
      end

      rst_all = 1'b0;
      for (int i = 0; i < 28; i++) begin
         drive(tbl[i].mk, tbl[i].vld, tbl[i].stp);
         tick();
         chk_out(1'b0, $sformatf("vec%0d", i), tbl[i].en, tbl[i].bx, tbl[i].f, tbl[i].nf,
                 tbl[i].cnt, tbl[i].se);
      end

      // long run: BX advances every 4 clocks and wraps 7 -> 0
      drive(3'b100, 3'b111, 1'b0);
      tick();
      chk_out(1'b0, "long.start", 1'b1, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0);
      drive(3'b000, 3'b111, 1'b0);
      for (int i = 1; i <= 49; i++) begin
         tick();
         chk_out(1'b0, $sformatf("long%0d", i), 1'b1, 3'((i / 4) % 8), (i % 4) == 0,
                 (i % 4) != 0, 2'(i % 4), 1'b0);
      end

      // asynchronous reset mid-run at BX=4, cnt=1
      #2 rst_any = 1'b0;
      #1 chk_out(1'b0, "async_rst", 1'b0, 3'd7, 1'b0, 1'b0, 2'd0, 1'b0);
      #2 rst_any = 1'b1;
      tick();
      chk_out(1'b0, "post_rst.idle", 1'b0, 3'd7, 1'b0, 1'b0, 2'd0, 1'b0);
      drive(3'b001, 3'b111, 1'b0);
      tick();
      chk_out(1'b0, "post_rst.start", 1'b1, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0);

      // ALL mode: ch0 @5, repeat ch0 @6, ch2 @7, ch1 @9 -> start after cycle 9
      rst_any = 1'b0;
      drive(3'b000, 3'b111, 1'b0);
      #2 rst_all = 1'b1;
      for (int c = 0; c < 10; c++) begin
         case (c)
            5, 6:    drive(3'b001, 3'b111, 1'b0);
            7:       drive(3'b100, 3'b111, 1'b0);
            9:       drive(3'b010, 3'b111, 1'b0);
            default: drive(3'b000, 3'b111, 1'b0);
         endcase
         tick();
         chk($sformatf("all%0d.en", c), 32'(b_en), 32'(c == 9));
      end
      chk_out(1'b1, "all.start", 1'b1, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0);
      drive(3'b000, 3'b111, 1'b0);
      tick();
      chk_out(1'b1, "all.run", 1'b1, 3'd0, 1'b0, 1'b1, 2'd1, 1'b0);
      drive(3'b000, 3'b111, 1'b1);
      tick();
      chk_out(1'b1, "all.stop", 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);

      // stop in IDLE discards partially collected markers
      drive(3'b001, 3'b111, 1'b0);
      tick();
      chk("all.seen0.en", 32'(b_en), 32'd0);
      drive(3'b000, 3'b111, 1'b1);
      tick();
      chk("all.clear.en", 32'(b_en), 32'd0);
      drive(3'b110, 3'b111, 1'b0);
      tick();
      chk("all.partial.en", 32'(b_en), 32'd0);
      drive(3'b001, 3'b111, 1'b0);
      tick();
      chk_out(1'b1, "all.restart", 1'b1, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
